// File: rtl/div_stage_ctrl.sv
// rtl/div_stage_ctrl.sv - sequencer around a combinational 5/3 divider
// Registers operands, screens zero/overflow, waits SETTLE_CYCLES, holds result.
module div_stage_ctrl #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [4:0] in_x,
  input  logic [2:0] in_d,
  output logic [4:0] div_x,
  output logic [2:0] div_d,
  input  logic [2:0] div_q,
  input  logic [2:0] div_r,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_q,
  output logic [2:0] out_r,
  output logic [1:0] out_err
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HOLD, OUT} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          div_zero;
  logic          ovf;

  assign in_ready = !rst && ((state == IDLE) || ((state == OUT) && out_ready));
  assign accept   = in_valid && in_ready;
  assign div_zero = (in_d == 3'd0);
  // quotient exceeds 7 exactly when the top two dividend bits reach the divisor
  assign ovf      = !div_zero && ({1'b0, in_x[4:3]} >= in_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      div_x     <= '0;
      div_d     <= '0;
      out_q     <= '0;
      out_r     <= '0;
      out_err   <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      div_x <= in_x;
      div_d <= in_d;
      if (div_zero || ovf) begin
        state     <= OUT;
        out_valid <= 1'b1;
        out_q     <= 3'b111;
        out_r     <= 3'b000;
        out_err   <= {ovf, div_zero};
      end else begin
        state     <= HOLD;
        cnt       <= CNT_INIT;
        out_valid <= 1'b0;
      end
    end else begin
      case (state)
        HOLD: begin
          if (cnt == '0) begin
            out_q     <= div_q;
            out_r     <= div_r;
            out_err   <= 2'b00;
            out_valid <= 1'b1;
            state     <= OUT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_stage_ctrl.sv
// tb/tb_div_stage_ctrl.sv - scoreboard bench, three SETTLE_CYCLES variants in parallel
// Divider model only shows the true result in the cycle the block should sample it.
module tb_div_stage_ctrl;

  typedef struct {
    int         cyc;
    logic [2:0] q;
    logic [2:0] r;
    logic [1:0] err;
  } exp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_chk = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input int k, input string nm, input int got, input int exp);
    n_chk = n_chk + 1;
    if (got == exp) n_pass = n_pass + 1;
    else $display("FAIL s%0d %s at cycle %0d: got %0d expected %0d", k, nm, cyc, got, exp);
  endtask

  for (genvar k = 0; k < 3; k++) begin : g
    localparam int S = (k == 0) ? 1 : (k == 1) ? 4 : 3;

    logic       rst, in_valid, in_ready, out_valid, out_ready;
    logic [4:0] in_x, div_x;
    logic [2:0] in_d, div_d, div_q, div_r, out_q, out_r;
    logic [1:0] out_err;

    exp_t       sb[$];
    logic [4:0] ops_x [256];
    logic [2:0] ops_d [256];
    int         idx = 0;
    int         samp = -1;
    logic [2:0] sq, sr;
    logic [4:0] lx = '0;
    logic [2:0] ld = '0;
    logic       rst_prev = 1'b0;

    div_stage_ctrl #(.SETTLE_CYCLES(S)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .in_d(in_d), .div_x(div_x), .div_d(div_d),
      .div_q(div_q), .div_r(div_r), .out_valid(out_valid), .out_ready(out_ready),
      .out_q(out_q), .out_r(out_r), .out_err(out_err)
    );

    // divider: garbage except in the single cycle the result must be sampled
    always @(posedge clk) begin
      #1;
      if (cyc == samp) begin
        div_q = sq;
        div_r = sr;
      end else begin
        div_q = 3'($urandom);
        div_r = 3'($urandom);
      end
    end

    initial begin
      int stall;
      ops_x[0] = 5'd19; ops_d[0] = 3'd3;
      ops_x[1] = 5'd13; ops_d[1] = 3'd0;
      ops_x[2] = 5'd31; ops_d[2] = 3'd2;
      ops_x[3] = 5'd31; ops_d[3] = 3'd4;
      ops_x[4] = 5'd7;  ops_d[4] = 3'd2;
      for (int i = 5; i < 256; i++) begin
        ops_x[i] = 5'($urandom);
        ops_d[i] = 3'($urandom);
      end
      div_q = '0; div_r = '0;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_x = '0; in_d = '0;
      stall = 0;
      repeat (2) @(posedge clk);
      for (int i = 0; i < 700; i++) begin
        #1;
        rst       = ($urandom % 80) == 0;
        in_valid  = ($urandom % 4) != 0;
        in_x      = ops_x[idx % 256];
        in_d      = ops_d[idx % 256];
        if (stall > 0) stall--;
        else if ($urandom % 16 == 0) stall = 5 + $urandom % 3;
        out_ready = (stall == 0) && (($urandom % 3) != 0);
        @(posedge clk);
      end
      #1;
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    end

    always @(negedge clk) begin
      logic vis, exp_rdy;
      int   ix, id;
      exp_t e;
      vis     = (sb.size() > 0) && (sb[0].cyc <= cyc);
      exp_rdy = !rst && ((sb.size() == 0) || (vis && out_ready));
      chk(k, "out_valid", int'(out_valid), int'(vis));
      chk(k, "in_ready", int'(in_ready), int'(exp_rdy));
      chk(k, "div_x", int'(div_x), int'(lx));
      chk(k, "div_d", int'(div_d), int'(ld));
      if (vis && out_valid) begin
        chk(k, "out_q", int'(out_q), int'(sb[0].q));
        chk(k, "out_r", int'(out_r), int'(sb[0].r));
        chk(k, "out_err", int'(out_err), int'(sb[0].err));
      end
      if (rst_prev) begin
        chk(k, "rst_out_q", int'(out_q), 0);
        chk(k, "rst_out_r", int'(out_r), 0);
        chk(k, "rst_out_err", int'(out_err), 0);
      end
      rst_prev = rst;
      if (rst) begin
        sb.delete();
        lx = '0;
        ld = '0;
        samp = -1;
      end else begin
        if (vis && out_ready) void'(sb.pop_front());
        if (in_valid && exp_rdy) begin
          ix = int'(in_x);
          id = int'(in_d);
          if (id == 0) begin
            e = '{cyc + 1, 3'd7, 3'd0, 2'b01};
          end else if (ix / id > 7) begin
            e = '{cyc + 1, 3'd7, 3'd0, 2'b10};
          end else begin
            e = '{cyc + S + 1, 3'(ix / id), 3'(ix % id), 2'b00};
            samp = cyc + S;
            sq = 3'(ix / id);
            sr = 3'(ix % id);
          end
          sb.push_back(e);
          lx = in_x;
          ld = in_d;
          idx++;
        end
      end
    end
  end

  initial begin
    repeat (720) @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/div_stage_ctrl.md
DIV_STAGE_CTRL -- requirements
Module: div_stage_ctrl

Interface
REQ-001 The block SHALL have one parameter: SETTLE_CYCLES, default 1, legal range 1..15, the number of cycles operands are held on the combinational 5/3 divider before its outputs are sampled.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  the operand pair is presented.
REQ-005 in_ready  output  1  the block accepts the operand pair this cycle.
REQ-006 in_x  input  5  dividend.
REQ-007 in_d  input  3  divisor.
REQ-008 div_x  output  5  registered dividend driven to the divider X[4:0].
REQ-009 div_d  output  3  registered divisor driven to the divider D[2:0].
REQ-010 div_q  input  3  divider quotient Q[2:0].
REQ-011 div_r  input  3  divider remainder R[2:0].
REQ-012 out_valid  output  1  a result is held.
REQ-013 out_ready  input  1  the consumer takes the result.
REQ-014 out_q  output  3  quotient result.
REQ-015 out_r  output  3  remainder result.
REQ-016 out_err  output  2  bit0 is divide-by-zero; bit1 is quotient overflow.

Function
REQ-017 The FSM SHALL have three states, IDLE, HOLD and OUT, with a down-counter of width ceil(log2(SETTLE_CYCLES+1)).
REQ-018 in_ready SHALL be 1 in IDLE, 1 in OUT only when out_ready=1, 0 in HOLD, and 0 whenever rst=1.
REQ-019 Accept SHALL mean in_valid&in_ready in cycle c; on accept, in_x/in_d SHALL be registered onto div_x/div_d, valid from cycle c+1.
REQ-020 div_x/div_d SHALL hold stable until the next accept.
REQ-021 Error classification SHALL happen at accept: D==0 is divide-by-zero; otherwise in_x[4:3] >= in_d is overflow, since the quotient does not fit in 3 bits.
REQ-022 On an error accept, the block SHALL go to OUT with out_q=3'b111, out_r=3'b000 and out_err set accordingly; out_valid SHALL be 1 in cycle c+1, and the divider SHALL NOT be sampled.
REQ-023 On a non-error accept, the block SHALL go to HOLD with counter=SETTLE_CYCLES-1.
REQ-024 In HOLD, the counter SHALL decrement each cycle; in the cycle the counter is 0, div_q/div_r SHALL be captured into out_q/out_r, out_err SHALL be set to 00, and the state SHALL move to OUT.
REQ-025 The result of a non-error accept SHALL appear with out_valid=1 in cycle c+SETTLE_CYCLES+1.
REQ-026 In OUT, out_valid SHALL be 1; out_q, out_r and out_err SHALL hold stable while out_ready=0.
REQ-027 In OUT, out_ready=1 with no accept SHALL move the state to IDLE and set out_valid=0 next cycle.
REQ-028 In OUT, out_ready=1 together with an accept SHALL complete both handshakes in the same cycle; the next state SHALL be HOLD or OUT per REQ-022/REQ-023, with no bubble for error operands.
REQ-029 out_valid SHALL be 0 in IDLE and HOLD.
REQ-030 in_x, in_d, div_q and div_r SHALL be ignored in all cycles other than the accept cycle and the HOLD sample cycle respectively.

Reset
REQ-031 rst=1 SHALL, at the next edge, force IDLE, counter=0, div_x=0, div_d=0, out_q=0, out_r=0, out_err=0 and out_valid=0, regardless of state.
REQ-032 rst=1 arriving in HOLD or OUT SHALL discard the in-flight operation; no out_valid SHALL follow after reset releases.
REQ-033 The first accept SHALL be possible in the first cycle with rst=0.

Verification
REQ-034 Assert rst for 2 cycles -> in_ready=0 during rst; all outputs are 0; in_ready=1 in the first cycle after release.
REQ-035 SETTLE_CYCLES=1, in_x=19, in_d=3, divider model returns Q=6, R=1 -> div_x=19, div_d=3 from c+1; out_valid=1 at c+2 with out_q=6, out_r=1, out_err=00.
REQ-036 in_x=13, in_d=0 -> out_valid=1 at c+1 with out_q=7, out_r=0, out_err=01; the div_q value is ignored.
REQ-037 in_x=31, in_d=2 -> out_valid=1 at c+1 with out_q=7, out_r=0, out_err=10; and in_x=31, in_d=4 -> no overflow, normal path.
REQ-038 SETTLE_CYCLES=4, a result is held with out_ready=0 for 5 cycles -> outputs are stable and in_ready=0; then out_ready=1 with in_valid=1 (in_x=7, in_d=2) in the same cycle -> both handshakes complete, HOLD lasts 4 cycles, and the next out_valid occurs at c+5.
REQ-039 rst asserted in the 2nd HOLD cycle with SETTLE_CYCLES=3 -> state is IDLE and out_valid=0 next cycle; no result is emitted afterwards.
